// File: rtl/uart_word_loader.sv
// uart_word_loader: parses framed load packets from a UART byte stream and
// writes little-endian 32-bit words sequentially into a memory write port.
//
// Handshake: i_Rx_DV is a valid-only, one-cycle pulse; the loader has no ready
// and consumes every byte on the cycle its DV is high, back-to-back included.
// Packet: A5, count lo, count hi, 4*count data bytes (LSB first), XOR checksum.
module uart_word_loader #(
  parameter int ADDR_WIDTH   = 10,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Mem_We,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [31:0]           o_Mem_Wdata,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Error,
  output logic [2:0]            o_State
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         TW        = $clog2(TIMEOUT_CLKS + 1);
  // Count value one short of the limit: one more idle cycle means timeout.
  localparam logic [TW-1:0] TLAST  = TW'(TIMEOUT_CLKS - 1);

  state_t                state, state_next;
  logic [7:0]            count_lo;
  logic [15:0]           remaining;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            lane;
  logic [23:0]           word;
  logic [7:0]            acc;
  logic [TW-1:0]         tcnt;

  logic do_we, do_done, do_err, timeout_hit;

  assign o_State = state;

  // Next-state and one-cycle event decode.
  always_comb begin
    state_next  = state;
    do_we       = 1'b0;
    do_done     = 1'b0;
    do_err      = 1'b0;
    // A DV on the limit cycle wins: the byte is consumed, no timeout.
    timeout_hit = (state != ST_IDLE) && !i_Rx_DV && (tcnt == TLAST);
    case (state)
      ST_IDLE: begin
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (i_Rx_DV) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (i_Rx_DV) begin
          if ({i_Rx_Byte, count_lo} == 16'd0) state_next = ST_CHECK;
          else                                 state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (i_Rx_DV && lane == 2'd3) begin
          do_we = 1'b1;
          if (remaining == 16'd1) state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == acc) do_done = 1'b1;
          else                  do_err  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (timeout_hit) begin
      state_next = ST_IDLE;
      do_err     = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Datapath: count, word assembly, checksum, timeout counter and outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      count_lo    <= '0;
      remaining   <= '0;
      addr        <= '0;
      lane        <= '0;
      word        <= '0;
      acc         <= '0;
      tcnt        <= '0;
      o_Mem_We    <= 1'b0;
      o_Mem_Addr  <= '0;
      o_Mem_Wdata <= '0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_Error     <= 1'b0;
    end else begin
      o_Mem_We <= do_we;
      o_Done   <= do_done;
      o_Error  <= do_err;
      o_Busy   <= (state_next != ST_IDLE);

      if (state_next == ST_IDLE || i_Rx_DV) tcnt <= '0;
      else                                  tcnt <= tcnt + 1'b1;

      if (i_Rx_DV) begin
        case (state)
          ST_LEN_LO: count_lo <= i_Rx_Byte;
          ST_LEN_HI: begin
            remaining <= {i_Rx_Byte, count_lo};
            addr      <= '0;
            lane      <= '0;
            acc       <= '0;
          end
          ST_DATA: begin
            acc  <= acc ^ i_Rx_Byte;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word[7:0]   <= i_Rx_Byte;
              2'd1: word[15:8]  <= i_Rx_Byte;
              2'd2: word[23:16] <= i_Rx_Byte;
              default: begin
                o_Mem_Wdata <= {i_Rx_Byte, word};
                o_Mem_Addr  <= addr;
                addr        <= addr + 1'b1;
                remaining   <= remaining - 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: directed packets plus randomized packets, with
// a queue-based scoreboard fed from a packet-level reference model.
module tb_uart_word_loader;

  localparam int AW = 2;
  localparam int TO = 50;
  localparam int W  = AW + 32;

  logic          clk;
  logic          i_Reset;
  logic          i_Rx_DV;
  logic [7:0]    i_Rx_Byte;
  logic          o_Mem_We;
  logic [AW-1:0] o_Mem_Addr;
  logic [31:0]   o_Mem_Wdata;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Error;
  logic [2:0]    dbg_state;

  uart_word_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock    (clk),
    .i_Reset    (i_Reset),
    .i_Rx_DV    (i_Rx_DV),
    .i_Rx_Byte  (i_Rx_Byte),
    .o_Mem_We   (o_Mem_We),
    .o_Mem_Addr (o_Mem_Addr),
    .o_Mem_Wdata(o_Mem_Wdata),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Error    (o_Error),
    .o_State    (dbg_state)
  );

  // Clock and reset-driver defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fails;
  logic [W-1:0] exp_q[$];   // expected {addr, data} writes
  logic [1:0]   exp_st[$];  // expected {error, done} status pulses
  logic [31:0]  pw[16];     // words of the packet being sent

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_Byte = b;
    i_Rx_DV   = 1'b1;
    @(posedge clk);
    #1;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'($urandom);
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    64'(o_Mem_We),    64'd0);
    check({tag, "_addr"},  64'(o_Mem_Addr),  64'd0);
    check({tag, "_wdata"}, 64'(o_Mem_Wdata), 64'd0);
    check({tag, "_busy"},  64'(o_Busy),      64'd0);
    check({tag, "_done"},  64'(o_Done),      64'd0);
    check({tag, "_error"}, 64'(o_Error),     64'd0);
    check({tag, "_state"}, 64'(dbg_state),   64'd0);
  endtask

  // Sends one packet of n words from pw[]. trunc > 0 stops after that many
  // bytes; then either a reset is applied (do_rst) or the line goes quiet.
  task automatic run_packet(input int n, input bit bad, input int trunc,
                            input int maxgap, input bit do_rst);
    logic [7:0] b[$];
    logic [7:0] ck;
    int sent, wc, c_hit;
    ck = 8'h00;
    b.push_back(8'hA5);
    b.push_back(n[7:0]);
    b.push_back(n[15:8]);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        b.push_back(pw[i][8*k +: 8]);
        ck = ck ^ pw[i][8*k +: 8];
      end
    b.push_back(bad ? (ck ^ 8'h01) : ck);

    // Model: every fully received word is written, address restarts at 0
    // each packet and wraps modulo 2^AW.
    sent = (trunc > 0) ? trunc : b.size();
    wc   = (sent > 3) ? (sent - 3) / 4 : 0;
    if (wc > n) wc = n;
    for (int i = 0; i < wc; i++) exp_q.push_back({AW'(i), pw[i]});
    if (trunc == 0)   exp_st.push_back(bad ? 2'b10 : 2'b01);
    else if (!do_rst) exp_st.push_back(2'b10);

    for (int i = 0; i < sent; i++) begin
      send_byte(b[i]);
      if (i != sent - 1) idle($urandom_range(0, maxgap));
    end

    if (trunc > 0 && do_rst) begin
      idle(1);
      i_Reset = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("mid_reset");
      i_Reset = 1'b0;
      idle(2);
      check_all_zero("post_reset");
    end else if (trunc > 0) begin
      c_hit = 0;
      for (int c = 1; c <= TO + 10; c++) begin
        @(posedge clk);
        #1;
        if (o_Error && c_hit == 0) c_hit = c;
      end
      check("timeout_latency", 64'(c_hit), 64'(TO));
      check("timeout_busy", 64'(o_Busy), 64'd0);
    end else begin
      idle(3);
      check("post_pkt_busy", 64'(o_Busy), 64'd0);
    end
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    check("status_drained", 64'(exp_st.size()), 64'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    i_Reset   = 1'b1;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
    fork
      // Monitor: compare every write and status pulse against the queues.
      forever begin
        @(negedge clk);
        if (!i_Reset) begin
          if (o_Mem_We) begin
            if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
            else check("write", 64'({o_Mem_Addr, o_Mem_Wdata}), 64'(exp_q.pop_front()));
          end
          if (o_Done || o_Error) begin
            check("done_err_excl", 64'(o_Done & o_Error), 64'd0);
            if (exp_st.size() == 0) check("unexpected_status", 64'd1, 64'd0);
            else check("status", 64'({o_Error, o_Done}), 64'(exp_st.pop_front()));
          end
        end
      end
      // Stimulus sequence
      begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        i_Reset = 1'b0;
        idle(2);

        // Basic load and bad checksum
        pw[0] = 32'h12345678;
        pw[1] = 32'hDEADBEEF;
        run_packet(2, 1'b0, 0, 2, 1'b0);
        run_packet(2, 1'b1, 0, 2, 1'b0);

        // Zero count preceded by noise
        send_byte(8'h00); check("noise_busy0", 64'(o_Busy), 64'd0);
        send_byte(8'hFF); check("noise_busy1", 64'(o_Busy), 64'd0);
        send_byte(8'h5A); check("noise_busy2", 64'(o_Busy), 64'd0);
        exp_st.push_back(2'b01);
        send_byte(8'hA5); check("zc_busy_sync", 64'(o_Busy), 64'd1);
        send_byte(8'h00); check("zc_busy_lo",   64'(o_Busy), 64'd1);
        send_byte(8'h00); check("zc_busy_hi",   64'(o_Busy), 64'd1);
        send_byte(8'h00); check("zc_busy_end",  64'(o_Busy), 64'd0);
        idle(2);
        check("zc_status_drained", 64'(exp_st.size()), 64'd0);

        // Timeout after A5 01 00 11 22, then a clean packet
        pw[0] = 32'h44332211;
        run_packet(1, 1'b0, 5, 1, 1'b0);
        pw[0] = 32'hCAFEF00D;
        run_packet(1, 1'b0, 0, 1, 1'b0);

        // Address wrap with back-to-back DV
        for (int i = 0; i < 5; i++) pw[i] = $urandom;
        run_packet(5, 1'b0, 0, 0, 1'b0);

        // Reset after 6 data bytes, then a fresh packet
        for (int i = 0; i < 2; i++) pw[i] = $urandom;
        run_packet(2, 1'b0, 9, 1, 1'b1);
        run_packet(2, 1'b0, 0, 1, 1'b0);

        // Randomized packets
        for (int p = 0; p < 25; p++) begin
          int n, tr;
          n = $urandom_range(0, 7);
          for (int i = 0; i < n; i++) pw[i] = $urandom;
          tr = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4 * n + 3) : 0;
          run_packet(n, ($urandom_range(0, 3) == 0), tr, $urandom_range(0, 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Byte-stream consumer placed directly downstream of the UART receiver. It takes the receiver's one-cycle byte-valid pulses, parses a framed load packet, and assembles little-endian 32-bit words. It writes each word sequentially into the CPU's instruction/data memory write port, then validates an XOR checksum. It is used to download a program image into the CPU over the serial link while the core is held idle.

## Interface
- ADDR_WIDTH, 10: width of the memory word address; the address wraps modulo 2^ADDR_WIDTH.
- TIMEOUT_CLKS, 100000: maximum number of i_Clock cycles allowed between bytes inside a packet; must be ≥ 1.

- i_Clock  in  1  system clock; the single clock domain.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_DV  in  1  byte-valid, a one-cycle pulse from the UART receiver.
- i_Rx_Byte  in  8  received byte; valid only while i_Rx_DV = 1.
- o_Mem_We  out  1  one-cycle word write strobe.
- o_Mem_Addr  out  ADDR_WIDTH  word address for the write.
- o_Mem_Wdata  out  32  write data.
- o_Busy  out  1  high while a packet is in progress (any state other than IDLE).
- o_Done  out  1  one-cycle pulse: packet complete, checksum OK.
- o_Error  out  1  one-cycle pulse: checksum mismatch or inter-byte timeout.

## Operation
- Packet format, in order:
  - sync byte 0xA5;
  - word count N, low byte then high byte (16-bit, unsigned);
  - 4·N data bytes, each word least-significant byte first;
  - checksum byte equal to the XOR of all 4·N data bytes.
- Bytes are consumed only on cycles with i_Rx_DV = 1.
- States and transitions:
  - **IDLE:** on a DV with byte 0xA5, go to LEN_LO. Any other byte is ignored and the state stays IDLE.
  - **LEN_LO:** latch count[7:0]; go to LEN_HI.
  - **LEN_HI:** latch count[15:8]. Clear the address, byte lane, and checksum accumulator. If the count is 0, go to CHECK; otherwise go to DATA.
  - **DATA:** on each byte:
    - place the byte into lane (0..3) of the word shift register;
    - XOR it into the accumulator;
    - increment the lane.
    - When lane 3 is filled: issue a write, increment the address, decrement the remaining-word count, and wrap the lane to 0.
    - When the remaining count reaches 0, go to CHECK.
  - **CHECK:** compare the byte with the accumulator. On match, pulse o_Done; on mismatch, pulse o_Error. Return to IDLE in both cases.
- Timeout:
  - A counter clears on every DV and increments on every other cycle while in a non-IDLE state.
  - When it reaches TIMEOUT_CLKS, pulse o_Error and return to IDLE. Any partial word is discarded and never written.
  - The counter is held at 0 in IDLE.
- Simultaneous events: a DV arriving on the same cycle the counter would reach TIMEOUT_CLKS takes priority. The byte is consumed and no error is raised.
- Address wrap: if N > 2^ADDR_WIDTH, the address wraps to 0 and writing continues (overwrites). This is not an error.
- Writes already issued are never retracted, even if the packet later errors.
- Word count is 16-bit; checksum is 8-bit XOR; no other arithmetic.

## Timing
- All outputs are registered.
- Reset values:
  - o_Mem_We = 0, o_Mem_Addr = 0, o_Mem_Wdata = 0;
  - o_Busy = 0, o_Done = 0, o_Error = 0;
  - state = IDLE; internal counters and accumulator = 0.
- Reset mid-packet abandons the packet on the next edge. No o_Done or o_Error is produced.
- Write latency: o_Mem_We is high for exactly one cycle, in the cycle after the DV carrying a word's 4th byte.
  - o_Mem_Addr and o_Mem_Wdata are valid in that same cycle.
  - Outside write cycles, o_Mem_Addr and o_Mem_Wdata hold their last values.
- o_Done and o_Error are asserted in the cycle after the checksum DV (or after the timeout cycle), for exactly one cycle. They are never asserted together.
- o_Busy rises the cycle after the sync-byte DV. It falls in the same cycle o_Done or o_Error asserts.
- Must accept DV pulses on consecutive cycles; there is no back-pressure.

## Test plan
- **Basic load:** send A5 02 00 78 56 34 12 EF BE AD DE, then the checksum byte (the XOR of the 8 data bytes).
  - Two writes: addr 0 = 0x12345678, addr 1 = 0xDEADBEEF.
  - o_Done pulses once; o_Error stays 0.
- **Bad checksum:** send the same packet with the checksum XORed with 0x01.
  - Both writes still occur.
  - o_Error pulses once; o_Done stays 0.
- **Zero count and noise:**
  - Send 00 FF 5A (garbage), then A5 00 00 00.
  - The garbage is ignored and no writes occur.
  - o_Done pulses; o_Busy is high only between the sync byte and the checksum.
- **Timeout:** with TIMEOUT_CLKS = 50, send A5 01 00 11 22, then idle for 60 cycles.
  - No write occurs.
  - o_Error pulses exactly 50 cycles after the last DV; o_Busy returns to 0.
  - A subsequent valid packet loads correctly at addr 0.
- **Wrap and back-to-back DV:** with ADDR_WIDTH = 2, send a 5-word packet with DV on every cycle.
  - Writes go to addresses 0, 1, 2, 3, 0, one cycle after each 4th byte.
  - o_Done pulses.
- **Reset mid-packet:** assert i_Reset after 6 data bytes of a 2-word packet.
  - Exactly one write occurs before reset.
  - After reset, all outputs are 0, with no o_Done or o_Error.
  - A fresh packet loads correctly.
